apb_master: RTL and testbench

- APB initiator (bridge) between a simple single-outstanding CPU request port and the APB peripherals; it is the other end of the APB slave interface used by the UART, GPIO and timer peripherals.
- Accepts one request, decodes the target slave from the address, and runs a standard SETUP/ACCESS APB transfer.
- Waits for PREADY from the selected slave, then returns read data or an error.
- Bus timeout and decode-miss errors are reported, so a dead or unmapped slave cannot hang the CPU.

---
 rtl/apb_pkg.sv | 23 ++
 rtl/apb_addr_decoder.sv | 41 ++++
 rtl/apb_master.sv | 225 ++++++++++++++++++++++
 tb/tb_apb_master.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB initiator and its address decoder.
//   APB_AW / APB_DW : APB address and data widths.
//   SLV_IDX_W       : width of the slave index carried from decode to the mux.
//   MAX_SLV         : largest slave count the fixed index width can address.
//   apb_state_e     : transfer state machine encoding.
// -----------------------------------------------------------------------------
package apb_pkg;

    localparam int unsigned APB_AW    = 32;
    localparam int unsigned APB_DW    = 32;
    localparam int unsigned SLV_IDX_W = 2;
    localparam int unsigned MAX_SLV   = 1 << SLV_IDX_W;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StResp   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_addr_decoder.sv
// -----------------------------------------------------------------------------
// apb_addr_decoder
// Purely combinational peripheral-window decoder.
//   i_addr : byte address of the request.
//   o_hit  : address lies inside the peripheral window (tag bits match).
//   o_idx  : slave index taken from the bits just above the per-slave span.
//   o_sel  : one-hot slave select; all zero on a window miss or when the
//            index names a slave that is not populated.
// -----------------------------------------------------------------------------
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter logic [APB_AW-1:0] BASE_ADDR = 32'h1000_0000,
    parameter int unsigned       SPAN_LOG2 = 12,
    parameter int unsigned       NUM_SLV   = 4
) (
    input  logic [APB_AW-1:0]    i_addr,
    output logic                 o_hit,
    output logic [SLV_IDX_W-1:0] o_idx,
    output logic [NUM_SLV-1:0]   o_sel
);

    // Lowest address bit that belongs to the window tag.
    localparam int unsigned TAG_LSB = SPAN_LOG2 + SLV_IDX_W;

    // Byte offset inside a slave region plays no part in the decode.
    logic w_unused_offset;
    assign w_unused_offset = ^i_addr[SPAN_LOG2-1:0];

    always_comb begin
        o_hit = (i_addr[APB_AW-1:TAG_LSB] == BASE_ADDR[APB_AW-1:TAG_LSB]);
        o_idx = i_addr[SPAN_LOG2 +: SLV_IDX_W];
        o_sel = '0;
        for (int i = 0; i < int'(NUM_SLV); i++) begin
            if (o_hit && (o_idx == SLV_IDX_W'(i))) begin
                o_sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
// APB initiator bridging a single-outstanding CPU request port onto up to four
// APB slaves. One request is accepted in IDLE, decoded, and run as a
// SETUP/ACCESS transfer; the response is a one-cycle pulse carrying read data
// or an error (decode miss or PREADY timeout). Every output is registered.
//
// Ports
//   PCLK, PRESET      : clock; asynchronous active-high reset.
//   req_valid/ready   : request handshake; ready only while idle.
//   req_addr/write/wdata : request payload, sampled on acceptance.
//   rsp_valid         : one-cycle response pulse.
//   rsp_rdata/rsp_err : response payload, held until the next response.
//   PADDR/PWDATA/PWRITE/PENABLE/PSEL : APB request signals.
//   PRDATA/PREADY     : per-slave read data (flattened) and ready.
// -----------------------------------------------------------------------------
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned       NUM_SLV   = 4,
    parameter logic [APB_AW-1:0] BASE_ADDR = 32'h1000_0000,
    parameter int unsigned       SPAN_LOG2 = 12,
    parameter int unsigned       TIMEOUT   = 255
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    // CPU request / response
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [APB_AW-1:0]         req_addr,
    input  logic                      req_write,
    input  logic [APB_DW-1:0]         req_wdata,
    output logic                      rsp_valid,
    output logic [APB_DW-1:0]         rsp_rdata,
    output logic                      rsp_err,
    // APB
    output logic [APB_AW-1:0]         PADDR,
    output logic [APB_DW-1:0]         PWDATA,
    output logic                      PWRITE,
    output logic                      PENABLE,
    output logic [NUM_SLV-1:0]        PSEL,
    input  logic [NUM_SLV*APB_DW-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY
);

    // Wide enough for the largest supported TIMEOUT (1023).
    localparam int unsigned CNT_W = 10;

    // -------------------------------------------------------------------------
    // Address decode of the incoming request
    // -------------------------------------------------------------------------
    logic                 w_dec_hit;
    logic [SLV_IDX_W-1:0] w_dec_idx;
    logic [NUM_SLV-1:0]   w_dec_sel;
    logic                 w_dec_ok;

    apb_addr_decoder #(
        .BASE_ADDR (BASE_ADDR),
        .SPAN_LOG2 (SPAN_LOG2),
        .NUM_SLV   (NUM_SLV)
    ) u_decoder (
        .i_addr (req_addr),
        .o_hit  (w_dec_hit),
        .o_idx  (w_dec_idx),
        .o_sel  (w_dec_sel)
    );

    // An in-window index beyond the populated slaves is still a miss.
    assign w_dec_ok = w_dec_hit && (32'(w_dec_idx) < NUM_SLV);

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    apb_state_e           r_state,     w_state_nxt;
    logic                 r_req_ready, w_req_ready_nxt;
    logic                 r_rsp_valid, w_rsp_valid_nxt;
    logic [APB_DW-1:0]    r_rsp_rdata, w_rsp_rdata_nxt;
    logic                 r_rsp_err,   w_rsp_err_nxt;
    logic [APB_AW-1:0]    r_paddr,     w_paddr_nxt;
    logic [APB_DW-1:0]    r_pwdata,    w_pwdata_nxt;
    logic                 r_pwrite,    w_pwrite_nxt;
    logic                 r_penable,   w_penable_nxt;
    logic [NUM_SLV-1:0]   r_psel,      w_psel_nxt;
    logic [CNT_W-1:0]     r_cnt,       w_cnt_nxt;
    logic [SLV_IDX_W-1:0] r_idx,       w_idx_nxt;

    // -------------------------------------------------------------------------
    // Selected-slave PREADY / PRDATA mux. Inputs are zero-padded to the full
    // index range so the latched index can always address them safely.
    // -------------------------------------------------------------------------
    logic [MAX_SLV-1:0]        w_pready_pad;
    logic [MAX_SLV*APB_DW-1:0] w_prdata_pad;
    logic                      w_pready_sel;
    logic [APB_DW-1:0]         w_prdata_sel;

    always_comb begin
        w_pready_pad                       = '0;
        w_pready_pad[NUM_SLV-1:0]          = PREADY;
        w_prdata_pad                       = '0;
        w_prdata_pad[NUM_SLV*APB_DW-1:0]   = PRDATA;
    end

    assign w_pready_sel = w_pready_pad[r_idx];
    assign w_prdata_sel = w_prdata_pad[{r_idx, 5'b0_0000} +: APB_DW];

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_req_ready_nxt = r_req_ready;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_pwrite_nxt    = r_pwrite;
        w_penable_nxt   = r_penable;
        w_psel_nxt      = r_psel;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;

        unique case (r_state)
            StIdle: begin
                if (req_valid && r_req_ready) begin
                    w_req_ready_nxt = 1'b0;
                    w_idx_nxt       = w_dec_idx;
                    if (w_dec_ok) begin
                        w_state_nxt   = StSetup;
                        w_psel_nxt    = w_dec_sel;
                        w_penable_nxt = 1'b0;
                        w_paddr_nxt   = req_addr;
                        w_pwdata_nxt  = req_wdata;
                        w_pwrite_nxt  = req_write;
                    end else begin
                        // Unmapped address: answer with an error, never touch the bus.
                        w_state_nxt     = StResp;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_rdata_nxt = '0;
                    end
                end
            end

            StSetup: begin
                w_state_nxt   = StAccess;
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = '0;
            end

            StAccess: begin
                // Ready wins over timeout, so a completion on the last allowed
                // cycle is still a success.
                if (w_pready_sel) begin
                    w_state_nxt     = StResp;
                    w_rsp_rdata_nxt = r_pwrite ? '0 : w_prdata_sel;
                    w_rsp_err_nxt   = 1'b0;
                    w_psel_nxt      = '0;
                    w_penable_nxt   = 1'b0;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_nxt     = StResp;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_err_nxt   = 1'b1;
                    w_psel_nxt      = '0;
                    w_penable_nxt   = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            StResp: begin
                w_rsp_valid_nxt = 1'b1;
                w_req_ready_nxt = 1'b1;
                w_state_nxt     = StIdle;
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state     <= StIdle;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_penable   <= 1'b0;
            r_psel      <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_penable   <= w_penable_nxt;
            r_psel      <= w_psel_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign PWRITE    = r_pwrite;
    assign PENABLE   = r_penable;
    assign PSEL      = r_psel;

endmodule

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
// Random and directed requests against apb_master with four behavioural APB
// slaves whose PREADY delay is chosen per transfer. Expected responses come
// from a window/memory reference model and are checked by a scoreboard.
// -----------------------------------------------------------------------------
module tb_apb_master;

    localparam int unsigned NSLV = 4;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int unsigned TMO  = 8;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic              req_write;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [31:0]       PADDR;
    logic [31:0]       PWDATA;
    logic              PWRITE;
    logic              PENABLE;
    logic [NSLV-1:0]   PSEL;
    logic [NSLV*32-1:0] PRDATA;
    logic [NSLV-1:0]   PREADY;

    apb_master #(
        .NUM_SLV   (NSLV),
        .BASE_ADDR (BASE),
        .SPAN_LOG2 (12),
        .TIMEOUT   (TMO)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PWRITE    (PWRITE),
        .PENABLE   (PENABLE),
        .PSEL      (PSEL),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;    // edges from acceptance to the rsp_valid cycle
        int          acc;    // expected PENABLE cycles
        int          t_acc;  // edge count at acceptance
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          n_push   = 0;
    int          n_flush  = 0;
    int          n_rsp    = 0;
    int          n_setup  = 0;

    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] slv_mem[32];
    int          acc_cnt[NSLV];

    int              cur_delay = 0;
    logic [NSLV-1:0] cur_psel  = '0;
    logic [31:0]     cur_addr  = '0;
    logic [31:0]     cur_wdata = '0;
    logic            cur_write = 1'b0;

    always @(posedge PCLK) cyc <= cyc + 1;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // -------------------------------------------------------------------------
    // Behavioural slaves: PREADY after cur_delay ACCESS cycles; unselected
    // slaves drive a poison pattern on PRDATA.
    // -------------------------------------------------------------------------
    initial begin
        forever begin
            @(posedge PCLK or posedge PRESET);
            for (int s = 0; s < NSLV; s++) begin
                if (PRESET) begin
                    acc_cnt[s] = 0;
                end else if (PSEL[s] && PENABLE) begin
                    if (PREADY[s]) begin
                        acc_cnt[s] = 0;
                        if (PWRITE) slv_mem[{PADDR[13:12], PADDR[4:2]}] = PWDATA;
                    end else begin
                        acc_cnt[s] = acc_cnt[s] + 1;
                    end
                end else begin
                    acc_cnt[s] = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge PCLK or posedge PRESET);
            for (int s = 0; s < NSLV; s++) begin
                if (PRESET) begin
                    PREADY[s]          = 1'b0;
                    PRDATA[s*32 +: 32] = 32'hDEAD_BEEF;
                end else begin
                    PREADY[s] = PSEL[s] && PENABLE && (acc_cnt[s] >= cur_delay);
                    PRDATA[s*32 +: 32] = (PSEL[s] && PENABLE) ?
                                         slv_mem[{PADDR[13:12], PADDR[4:2]}] : 32'hDEAD_BEEF;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Monitor / scoreboard
    // -------------------------------------------------------------------------
    initial begin
        logic            prev_rv;
        logic            prev_rr;
        int              en_cnt;
        logic [31:0]     h_addr;
        logic [31:0]     h_wdata;
        logic [NSLV-1:0] h_psel;
        exp_t            e;
        prev_rv = 1'b0;
        prev_rr = 1'b1;
        en_cnt  = 0;
        h_addr  = '0;
        h_wdata = '0;
        h_psel  = '0;
        forever begin
            @(negedge PCLK);
            if (PRESET) begin
                en_cnt  = 0;
                prev_rv = 1'b0;
                prev_rr = 1'b1;
            end else begin
                if ((PSEL != '0) && !PENABLE) begin
                    chk("setup_psel", 32'(PSEL), 32'(cur_psel));
                    chk("setup_paddr", PADDR, cur_addr);
                    chk("setup_pwrite", 32'(PWRITE), 32'(cur_write));
                    if (cur_write) chk("setup_pwdata", PWDATA, cur_wdata);
                    chk("setup_after_ready", 32'(prev_rr), 32'd1);
                    h_addr  = PADDR;
                    h_wdata = PWDATA;
                    h_psel  = PSEL;
                    n_setup++;
                end
                if (PENABLE) begin
                    en_cnt++;
                    chk("access_paddr", PADDR, h_addr);
                    chk("access_pwdata", PWDATA, h_wdata);
                    chk("access_psel", 32'(PSEL), 32'(h_psel));
                end
                if (rsp_valid) begin
                    chk("rsp_pulse_width", 32'(prev_rv), 32'd0);
                    if (sb.size() == 0) begin
                        fail_now("unexpected_response");
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_err", 32'(rsp_err), 32'(e.err));
                        chk("rsp_latency", 32'(cyc - e.t_acc), 32'(e.lat));
                        chk("penable_cycles", 32'(en_cnt), 32'(e.acc));
                    end
                    en_cnt = 0;
                    n_rsp++;
                end
                prev_rv = rsp_valid;
                prev_rr = req_ready;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver with reference model applied at the acceptance edge
    // -------------------------------------------------------------------------
    task automatic send(input logic [31:0] a, input logic w, input logic [31:0] wd, input int d);
        int          budget;
        exp_t        e;
        logic [31:0] off;
        logic        hit;
        int          s;
        @(negedge PCLK);
        req_addr  = a;
        req_write = w;
        req_wdata = wd;
        req_valid = 1'b1;
        budget    = 0;
        while (!req_ready && budget < 2000) begin
            @(negedge PCLK);
            budget++;
        end
        if (!req_ready) begin
            fail_now("accept_timeout");
            req_valid = 1'b0;
            return;
        end
        @(posedge PCLK);
        #1;
        off = a - BASE;
        hit = (a >= BASE) && (off < NSLV * 4096);
        s   = int'(off / 32'd4096);
        e.t_acc   = cyc;
        cur_addr  = a;
        cur_wdata = wd;
        cur_write = w;
        cur_delay = d;
        if (!hit) begin
            cur_psel = '0;
            e.rdata  = '0;
            e.err    = 1'b1;
            e.lat    = 1;
            e.acc    = 0;
        end else begin
            cur_psel = NSLV'(1) << s;
            if (d >= int'(TMO)) begin
                e.rdata = '0;
                e.err   = 1'b1;
                e.lat   = TMO + 2;
                e.acc   = TMO;
            end else begin
                e.err = 1'b0;
                e.lat = d + 3;
                e.acc = d + 1;
                if (w) begin
                    e.rdata    = '0;
                    ref_mem[a] = wd;
                end else begin
                    e.rdata = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
                end
            end
        end
        sb.push_back(e);
        n_push++;
    endtask

    task automatic idle(input int n);
        @(negedge PCLK);
        req_valid = 1'b0;
        repeat (n) @(negedge PCLK);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (sb.size() != 0 && b < 500) begin
            @(negedge PCLK);
            b++;
        end
        if (sb.size() != 0) fail_now("drain_timeout");
        @(negedge PCLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dly_tab[8];
        logic [31:0] a;
        int          r;
        int          s0;
        int          r0;
        int          b;
        dly_tab = '{0, 0, 1, 2, 3, TMO - 1, TMO, 1000};
        for (int s = 0; s < NSLV; s++) begin
            for (int w = 0; w < 8; w++) begin
                slv_mem[s*8 + w] = dflt(BASE + 32'(s * 4096) + 32'(w * 4));
            end
        end
        PRESET    = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_write = 1'b0;
        req_wdata = '0;
        #12;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_psel", 32'(PSEL), 32'd0);
        chk("reset_penable", 32'(PENABLE), 32'd0);
        chk("reset_paddr", PADDR, 32'd0);
        chk("reset_pwdata", PWDATA, 32'd0);
        chk("reset_pwrite", 32'(PWRITE), 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;

        // Directed: write slave 2, write/read slave 3, window miss, timeout, recovery.
        send(32'h1000_2008, 1'b1, 32'h0000_0041, 1);
        send(32'h1000_300C, 1'b1, 32'h0000_005A, 0);
        send(32'h1000_300C, 1'b0, 32'h0, 2);
        idle(2);
        send(32'h2000_0000, 1'b0, 32'h0, 0);
        send(32'h1000_1004, 1'b0, 32'h0, 1000);
        send(32'h1000_0000, 1'b0, 32'h0, 0);
        idle(1);
        drain();

        // Reset in the first ACCESS cycle.
        send(32'h1000_0004, 1'b0, 32'h0, 20);
        @(negedge PCLK);
        req_valid = 1'b0;
        b = 0;
        while (!PENABLE && b < 50) begin
            @(negedge PCLK);
            b++;
        end
        if (!PENABLE) fail_now("access_not_reached");
        #1;
        PRESET = 1'b1;
        #1;
        chk("mid_reset_psel", 32'(PSEL), 32'd0);
        chk("mid_reset_penable", 32'(PENABLE), 32'd0);
        chk("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        n_flush += sb.size();
        sb.delete();
        repeat (2) @(negedge PCLK);
        #1;
        PRESET = 1'b0;
        #1;
        chk("post_reset_req_ready", 32'(req_ready), 32'd1);
        repeat (6) @(negedge PCLK);

        // Two writes with req_valid held high throughout.
        s0 = n_setup;
        r0 = n_rsp;
        send(32'h1000_0008, 1'b1, 32'hCAFE_0001, 0);
        send(32'h1000_0010, 1'b1, 32'hCAFE_0002, 1);
        idle(1);
        drain();
        chk("b2b_setups", 32'(n_setup - s0), 32'd2);
        chk("b2b_responses", 32'(n_rsp - r0), 32'd2);

        // Randomised traffic.
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 19);
            if (r < 17) begin
                a = BASE + ($urandom_range(0, NSLV - 1) << 12) + ($urandom_range(0, 7) << 2);
            end else if (r == 17) begin
                a = BASE - 32'd4;
            end else if (r == 18) begin
                a = BASE + NSLV * 4096;
            end else begin
                a = 32'h2000_0000 + ($urandom_range(0, 7) << 2);
            end
            send(a, 1'($urandom_range(0, 1)), $urandom, dly_tab[$urandom_range(0, 7)]);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
        end
        idle(1);
        drain();

        chk("all_responses", 32'(n_rsp), 32'(n_push - n_flush));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
